interact_ctrl: RTL and testbench

- Handles the player's "interact" action, which the enter key triggers.
- Sits downstream of the player movement block and consumes player_x, player_y and the move pulses.
- Reads the map tile the player faces through map BRAM port b and decides the outcome: pick up a key, open a door, or deny.
- Writes the modified tile back through the same port and keeps the key inventory. The render stage then shows the changed map on the next frame scan.

---
 rtl/game_params.sv | 50 +++++
 rtl/interact_ctrl_target_calc.sv | 50 +++++
 rtl/interact_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_interact_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_params.sv
// Shared game constants: map geometry, tile ids, facing encodings and the
// interact controller's FSM state codes and outcome type.
package game_params;

    localparam int unsigned MAP_WIDTH  = 32'd16;
    localparam int unsigned MAP_HEIGHT = 32'd12;

    localparam logic [15:0] TILE_FLOOR = 16'd0;
    localparam logic [15:0] TILE_WALL  = 16'd1;
    localparam logic [15:0] TILE_KEY   = 16'd2;
    localparam logic [15:0] TILE_DOOR  = 16'd3;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_DECIDE = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [1:0] {
        OUT_NONE   = 2'd0,
        OUT_PICKUP = 2'd1,
        OUT_DOOR   = 2'd2,
        OUT_DENY   = 2'd3
    } outcome_e;

    // Move pulses are {right,up,down,left}; when several are set the
    // leftmost wins. No pulse keeps the current facing.
    function automatic logic [1:0] next_facing(input logic [3:0] move,
                                               input logic [1:0] cur);
        logic [1:0] f;
        if (move[3]) begin
            f = DIR_RIGHT;
        end else if (move[2]) begin
            f = DIR_UP;
        end else if (move[1]) begin
            f = DIR_DOWN;
        end else if (move[0]) begin
            f = DIR_LEFT;
        end else begin
            f = cur;
        end
        return f;
    endfunction

endpackage

// File: rtl/interact_ctrl_target_calc.sv
// Combinational facing + position -> tile address and in-bounds flag.
// Arithmetic is 5 bits wide so a step off the left/top edge shows up as a
// borrow instead of silently wrapping into the map.
module target_calc #(
    parameter int unsigned MAP_WIDTH  = game_params::MAP_WIDTH,
    parameter int unsigned MAP_HEIGHT = game_params::MAP_HEIGHT
) (
    input  logic [1:0]  facing,
    input  logic [3:0]  pos_x,
    input  logic [3:0]  pos_y,
    output logic [18:0] addr,
    output logic        in_bounds
);
    import game_params::*;

    logic [4:0] dx_s;
    logic [4:0] dy_s;
    logic [4:0] tx_s;
    logic [4:0] ty_s;
    logic       x_ok_s;
    logic       y_ok_s;

    // Unit step for the current facing, as 5-bit two's complement.
    always_comb begin
        dx_s = 5'd0;
        dy_s = 5'd0;
        case (facing)
            DIR_RIGHT: dx_s = 5'd1;
            DIR_LEFT:  dx_s = 5'h1F;
            DIR_UP:    dy_s = 5'h1F;
            DIR_DOWN:  dy_s = 5'd1;
            default: begin
                dx_s = 5'd0;
                dy_s = 5'd0;
            end
        endcase
    end

    // Target coordinates, bounds and linear address (y*MAP_WIDTH + x).
    always_comb begin
        tx_s      = {1'b0, pos_x} + dx_s;
        ty_s      = {1'b0, pos_y} + dy_s;
        // A negative step that leaves bit 4 set means we went below zero.
        x_ok_s    = !(dx_s[4] && tx_s[4]) && ({27'd0, tx_s} < MAP_WIDTH);
        y_ok_s    = !(dy_s[4] && ty_s[4]) && ({27'd0, ty_s} < MAP_HEIGHT);
        in_bounds = x_ok_s && y_ok_s;
        addr      = (19'(ty_s) * 19'(MAP_WIDTH)) + 19'(tx_s);
    end

endmodule

// File: rtl/interact_ctrl.sv
// Player "interact" handler: on enter, reads the faced map tile through
// BRAM port b, picks up keys / opens doors by writing the floor tile back,
// and maintains the key inventory. All outputs are registered.
module interact_ctrl #(
    parameter int unsigned MAP_WIDTH  = 32'd16,
    parameter int unsigned MAP_HEIGHT = 32'd12,
    parameter int unsigned RD_LAT     = 32'd1,
    parameter int unsigned KEY_MAX    = 32'd15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  move,
    input  logic        enter,
    input  logic [3:0]  player_x,
    input  logic [3:0]  player_y,
    output logic [18:0] bram_addr,
    input  logic [15:0] bram_rdata,
    output logic        bram_we,
    output logic [15:0] bram_wdata,
    output logic        busy,
    output logic [3:0]  key_count,
    output logic        ev_pickup,
    output logic        ev_door,
    output logic        ev_deny
);
    import game_params::*;

    // Counter preload: READ lasts RD_LAT cycles, sampling the tile on the
    // RD_LAT-th edge after the address edge.
    localparam logic [1:0] RD_CNT_INIT = 2'(RD_LAT - 32'd1);
    localparam logic [3:0] KEY_MAX_C   = 4'(KEY_MAX);

    logic [2:0]  state_r,     state_s;
    logic [1:0]  facing_r,    facing_s;
    logic [1:0]  rd_cnt_r,    rd_cnt_s;
    logic [15:0] tile_r,      tile_s;
    outcome_e    outcome_r,   outcome_s;
    logic [18:0] bram_addr_r, bram_addr_s;
    logic        bram_we_r,   bram_we_s;
    logic [15:0] bram_wdata_r, bram_wdata_s;
    logic        busy_r,      busy_s;
    logic [3:0]  key_count_r, key_count_s;
    logic        ev_pickup_r, ev_pickup_s;
    logic        ev_door_r,   ev_door_s;
    logic        ev_deny_r,   ev_deny_s;

    logic [18:0] tgt_addr_s;
    logic        tgt_in_bounds_s;

    target_calc #(
        .MAP_WIDTH (MAP_WIDTH),
        .MAP_HEIGHT(MAP_HEIGHT)
    ) u_target (
        .facing   (facing_r),
        .pos_x    (player_x),
        .pos_y    (player_y),
        .addr     (tgt_addr_s),
        .in_bounds(tgt_in_bounds_s)
    );

    // Next-state logic for the interaction FSM, inventory and event pulses.
    always_comb begin
        state_s      = state_r;
        facing_s     = next_facing(move, facing_r);
        rd_cnt_s     = rd_cnt_r;
        tile_s       = tile_r;
        outcome_s    = outcome_r;
        bram_addr_s  = bram_addr_r;
        bram_we_s    = 1'b0;
        bram_wdata_s = bram_wdata_r;
        busy_s       = busy_r;
        key_count_s  = key_count_r;
        ev_pickup_s  = 1'b0;
        ev_door_s    = 1'b0;
        ev_deny_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                outcome_s = OUT_NONE;
                if (enter) begin
                    busy_s = 1'b1;
                    if (tgt_in_bounds_s) begin
                        bram_addr_s = tgt_addr_s;
                        rd_cnt_s    = RD_CNT_INIT;
                        state_s     = ST_READ;
                    end else begin
                        // Off the map: deny without touching the BRAM.
                        outcome_s = OUT_DENY;
                        state_s   = ST_DONE;
                    end
                end else begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_cnt_r == 2'd0) begin
                    tile_s  = bram_rdata;
                    state_s = ST_DECIDE;
                end else begin
                    rd_cnt_s = rd_cnt_r - 2'd1;
                    state_s  = ST_READ;
                end
            end
            ST_DECIDE: begin
                if (tile_r == TILE_KEY) begin
                    bram_wdata_s = TILE_FLOOR;
                    bram_we_s    = 1'b1;
                    outcome_s    = OUT_PICKUP;
                    state_s      = ST_WRITE;
                end else if ((tile_r == TILE_DOOR) && (key_count_r != 4'd0)) begin
                    bram_wdata_s = TILE_FLOOR;
                    bram_we_s    = 1'b1;
                    outcome_s    = OUT_DOOR;
                    state_s      = ST_WRITE;
                end else if (tile_r == TILE_DOOR) begin
                    outcome_s = OUT_DENY;
                    state_s   = ST_DONE;
                end else begin
                    outcome_s = OUT_NONE;
                    state_s   = ST_DONE;
                end
            end
            ST_WRITE: begin
                bram_we_s = 1'b0;
                state_s   = ST_DONE;
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase

        // DONE always exits to IDLE, so a DONE next state means we are
        // entering it: raise the event for that cycle and settle inventory.
        if (state_s == ST_DONE) begin
            case (outcome_s)
                OUT_PICKUP: begin
                    ev_pickup_s = 1'b1;
                    if (key_count_r < KEY_MAX_C) begin
                        key_count_s = key_count_r + 4'd1;
                    end else begin
                        key_count_s = key_count_r;
                    end
                end
                OUT_DOOR: begin
                    ev_door_s = 1'b1;
                    if (key_count_r != 4'd0) begin
                        key_count_s = key_count_r - 4'd1;
                    end else begin
                        key_count_s = key_count_r;
                    end
                end
                OUT_DENY: begin
                    ev_deny_s = 1'b1;
                end
                default: begin
                    key_count_s = key_count_r;
                end
            endcase
        end else begin
            ev_pickup_s = 1'b0;
            ev_door_s   = 1'b0;
            ev_deny_s   = 1'b0;
        end
    end

    // State and output registers; reset aborts any interaction in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            facing_r     <= DIR_DOWN;
            rd_cnt_r     <= 2'd0;
            tile_r       <= 16'd0;
            outcome_r    <= OUT_NONE;
            bram_addr_r  <= 19'd0;
            bram_we_r    <= 1'b0;
            bram_wdata_r <= 16'd0;
            busy_r       <= 1'b0;
            key_count_r  <= 4'd0;
            ev_pickup_r  <= 1'b0;
            ev_door_r    <= 1'b0;
            ev_deny_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            facing_r     <= facing_s;
            rd_cnt_r     <= rd_cnt_s;
            tile_r       <= tile_s;
            outcome_r    <= outcome_s;
            bram_addr_r  <= bram_addr_s;
            bram_we_r    <= bram_we_s;
            bram_wdata_r <= bram_wdata_s;
            busy_r       <= busy_s;
            key_count_r  <= key_count_s;
            ev_pickup_r  <= ev_pickup_s;
            ev_door_r    <= ev_door_s;
            ev_deny_r    <= ev_deny_s;
        end
    end

    assign bram_addr  = bram_addr_r;
    assign bram_we    = bram_we_r;
    assign bram_wdata = bram_wdata_r;
    assign busy       = busy_r;
    assign key_count  = key_count_r;
    assign ev_pickup  = ev_pickup_r;
    assign ev_door    = ev_door_r;
    assign ev_deny    = ev_deny_r;

endmodule

// File: tb/tb_interact_ctrl.sv
// Bench for interact_ctrl: a BRAM model, a reference game model that
// predicts each accepted interaction, and a monitor that pops predictions
// whenever busy falls or a write is issued.
module tb_interact_ctrl;
    import game_params::*;

    localparam int W   = 16;
    localparam int H   = 12;
    localparam int RDL = 2;
    localparam int NT  = W * H;

    localparam int EV_NONE = 0;
    localparam int EV_PICK = 1;
    localparam int EV_DOOR = 2;
    localparam int EV_DENY = 3;

    localparam int F_RIGHT = 0;
    localparam int F_UP    = 1;
    localparam int F_DOWN  = 2;
    localparam int F_LEFT  = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  move = 4'd0;
    logic        enter = 1'b0;
    logic [3:0]  player_x = 4'd0;
    logic [3:0]  player_y = 4'd0;
    logic [18:0] bram_addr;
    logic [15:0] bram_rdata;
    logic        bram_we;
    logic [15:0] bram_wdata;
    logic        busy;
    logic [3:0]  key_count;
    logic        ev_pickup;
    logic        ev_door;
    logic        ev_deny;

    interact_ctrl #(
        .MAP_WIDTH (W),
        .MAP_HEIGHT(H),
        .RD_LAT    (RDL),
        .KEY_MAX   (15)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .move      (move),
        .enter     (enter),
        .player_x  (player_x),
        .player_y  (player_y),
        .bram_addr (bram_addr),
        .bram_rdata(bram_rdata),
        .bram_we   (bram_we),
        .bram_wdata(bram_wdata),
        .busy      (busy),
        .key_count (key_count),
        .ev_pickup (ev_pickup),
        .ev_door   (ev_door),
        .ev_deny   (ev_deny)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- BRAM model ----------------
    logic [15:0] mem [0:NT-1];
    logic [15:0] rd_now;
    logic [15:0] pipe1 = 16'd0;
    logic [15:0] pipe2 = 16'd0;
    logic        pl_en = 1'b0;
    int          pl_addr = 0;
    logic [15:0] pl_data = 16'd0;

    assign rd_now = (int'(bram_addr) < NT) ? mem[int'(bram_addr)] : 16'd0;

    always @(posedge clk) begin
        if (bram_we && (int'(bram_addr) < NT)) mem[int'(bram_addr)] <= bram_wdata;
        if (pl_en) mem[pl_addr] <= pl_data;
        pipe1 <= rd_now;
        pipe2 <= pipe1;
    end

    assign bram_rdata = (RDL == 1) ? rd_now : ((RDL == 2) ? pipe1 : pipe2);

    // ---------------- reference model ----------------
    typedef struct { int ev; int keys; int dur; int addr; } exp_t;
    typedef struct { int addr; int data; } wr_t;
    exp_t sb_q[$];
    wr_t  wr_q[$];

    int m_map [NT];
    int m_keys = 0;
    int m_face = F_DOWN;
    int m_free = 0;
    int m_last_addr = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, exp_v, $time);
        end
    endtask

    // One clock of stimulus; runs the model for an enter accepted on the next edge.
    task automatic do_cycle(input logic [3:0] mv, input logic en);
        int e, dx, dy, tx, ty, a, t;
        exp_t x;
        wr_t  w;
        e = cyc + 1;
        move  = mv;
        enter = en;
        if (en && (e >= m_free)) begin
            dx = (m_face == F_RIGHT) ? 1 : ((m_face == F_LEFT) ? -1 : 0);
            dy = (m_face == F_DOWN)  ? 1 : ((m_face == F_UP)   ? -1 : 0);
            tx = int'(player_x) + dx;
            ty = int'(player_y) + dy;
            if (tx < 0 || tx >= W || ty < 0 || ty >= H) begin
                x.ev  = EV_DENY;
                x.dur = 1;
            end else begin
                a = ty * W + tx;
                m_last_addr = a;
                t = m_map[a];
                if (t == int'(TILE_KEY) || (t == int'(TILE_DOOR) && m_keys > 0)) begin
                    if (t == int'(TILE_KEY)) begin
                        x.ev = EV_PICK;
                        m_keys = (m_keys < 15) ? m_keys + 1 : 15;
                    end else begin
                        x.ev = EV_DOOR;
                        m_keys = m_keys - 1;
                    end
                    m_map[a] = int'(TILE_FLOOR);
                    w.addr = a;
                    w.data = int'(TILE_FLOOR);
                    wr_q.push_back(w);
                    x.dur = RDL + 3;
                end else begin
                    x.ev  = (t == int'(TILE_DOOR)) ? EV_DENY : EV_NONE;
                    x.dur = RDL + 2;
                end
            end
            x.keys = m_keys;
            x.addr = m_last_addr;
            sb_q.push_back(x);
            m_free = e + x.dur + 1;
        end
        if (mv[3])      m_face = F_RIGHT;
        else if (mv[2]) m_face = F_UP;
        else if (mv[1]) m_face = F_DOWN;
        else if (mv[0]) m_face = F_LEFT;
        @(posedge clk);
        #1;
        move  = 4'd0;
        enter = 1'b0;
    endtask

    task automatic preload(input int a, input int t);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = 16'(t);
        m_map[a] = t;
        do_cycle(4'd0, 1'b0);
        pl_en = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc + 1 < m_free) do_cycle(4'd0, 1'b0);
    endtask

    task automatic interact();
        do_cycle(4'd0, 1'b1);
        wait_idle();
    endtask

    // ---------------- monitor ----------------
    initial begin
        int win, n_pk, n_dr, n_dn;
        logic prev;
        exp_t x;
        wr_t  w;
        prev = 1'b0; win = 0; n_pk = 0; n_dr = 0; n_dn = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev = 1'b0; win = 0; n_pk = 0; n_dr = 0; n_dn = 0;
            end else begin
                if (bram_we) begin
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write addr %0d data %0d, expected no write", bram_addr, bram_wdata);
                    end else begin
                        w = wr_q.pop_front();
                        chk("wr_addr", int'(bram_addr), w.addr);
                        chk("wr_data", int'(bram_wdata), w.data);
                    end
                end
                if (busy) begin
                    win++;
                    n_pk += int'(ev_pickup);
                    n_dr += int'(ev_door);
                    n_dn += int'(ev_deny);
                end else begin
                    if (ev_pickup || ev_door || ev_deny) begin
                        checks++;
                        errors++;
                        $display("FAIL event_outside_busy pk %0b dr %0b dn %0b, expected none", ev_pickup, ev_door, ev_deny);
                    end
                    if (prev) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_busy length %0d, expected no interaction", win);
                        end else begin
                            x = sb_q.pop_front();
                            chk("busy_len", win, x.dur);
                            chk("ev_pickup_cnt", n_pk, (x.ev == EV_PICK) ? 1 : 0);
                            chk("ev_door_cnt", n_dr, (x.ev == EV_DOOR) ? 1 : 0);
                            chk("ev_deny_cnt", n_dn, (x.ev == EV_DENY) ? 1 : 0);
                            chk("key_count", int'(key_count), x.keys);
                            chk("bram_addr", int'(bram_addr), x.addr);
                        end
                        win = 0; n_pk = 0; n_dr = 0; n_dn = 0;
                    end
                end
                prev = busy;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int saved, mism;
        logic [3:0] mv;
        logic en;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_keys", int'(key_count), 0);
        chk("rst_addr", int'(bram_addr), 0);
        chk("rst_we", int'(bram_we), 0);
        chk("rst_wdata", int'(bram_wdata), 0);
        chk("rst_events", int'({ev_pickup, ev_door, ev_deny}), 0);

        for (int i = 0; i < NT; i++) preload(i, int'($urandom_range(0, 3)));
        rstn = 1'b1;
        do_cycle(4'd0, 1'b0);

        // Facing is DOWN out of reset: (3,4) -> (3,5), a plain floor tile.
        player_x = 4'd3; player_y = 4'd4;
        preload(83, int'(TILE_FLOOR));
        interact();

        // Key to the right of (3,4) at address 68.
        preload(68, int'(TILE_KEY));
        do_cycle(4'b1000, 1'b0);
        interact();

        // Door above (5,5) at address 69: open with the key, then deny with none.
        player_x = 4'd5; player_y = 4'd5;
        preload(69, int'(TILE_DOOR));
        do_cycle(4'b0100, 1'b0);
        interact();
        preload(69, int'(TILE_DOOR));
        interact();

        // Map edges, including multi-bit move priority.
        player_x = 4'd0; player_y = 4'd0;
        do_cycle(4'b0001, 1'b0);
        interact();
        do_cycle(4'b0111, 1'b0);
        interact();
        player_x = 4'd15; player_y = 4'd11;
        do_cycle(4'b1001, 1'b0);
        interact();
        do_cycle(4'b0011, 1'b0);
        interact();

        // Enter while busy is dropped; a move mid-operation only retargets later.
        player_x = 4'd3; player_y = 4'd4;
        preload(68, int'(TILE_KEY));
        do_cycle(4'b1000, 1'b0);
        do_cycle(4'd0, 1'b1);
        do_cycle(4'd0, 1'b0);
        do_cycle(4'd0, 1'b1);
        do_cycle(4'b0100, 1'b0);
        wait_idle();
        preload(51, int'(TILE_KEY));
        interact();

        // Key inventory saturates at 15 while tiles are still consumed.
        player_x = 4'd8; player_y = 4'd8;
        do_cycle(4'b1000, 1'b0);
        for (int i = 0; i < 17; i++) begin
            preload(137, int'(TILE_KEY));
            interact();
        end
        chk("key_saturated", int'(key_count), 15);

        // Reset during READ: abort, inventory cleared, tile untouched.
        preload(137, int'(TILE_KEY));
        saved = m_map[137];
        do_cycle(4'd0, 1'b1);
        rstn = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_keys", int'(key_count), 0);
        sb_q.delete();
        wr_q.delete();
        m_map[137]  = saved;
        m_keys      = 0;
        m_face      = F_DOWN;
        m_last_addr = 0;
        m_free      = 0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        player_x = 4'd9; player_y = 4'd7;
        do_cycle(4'd0, 1'b0);
        interact();

        // Randomized play.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                player_x = 4'($urandom_range(0, 15));
                player_y = 4'($urandom_range(0, 12));
            end
            if (($urandom_range(0, 9) == 0) && (cyc + 1 >= m_free)) begin
                preload(int'($urandom_range(0, NT - 1)), int'($urandom_range(2, 3)));
            end
            mv = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            en = ($urandom_range(0, 3) == 0);
            do_cycle(mv, en);
        end
        wait_idle();
        repeat (6) do_cycle(4'd0, 1'b0);

        chk("sb_drained", sb_q.size(), 0);
        chk("wr_drained", wr_q.size(), 0);
        mism = 0;
        for (int i = 0; i < NT; i++) if (int'(mem[i]) != m_map[i]) mism++;
        chk("map_contents", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
